i2c_cmd_sequencer: RTL and testbench



---
 rtl/i2c_seq_pkg.sv | 24 ++
 rtl/i2c_init_rom.sv | 26 ++
 rtl/i2c_cmd_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM state encoding,
// init-table entry layout and the response watchdog limit.
package i2c_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE            = 4'd0,
        ST_STARTUP         = 4'd1,
        ST_INIT_ISSUE      = 4'd2,
        ST_INIT_WAIT       = 4'd3,
        ST_POLL_ISSUE      = 4'd4,
        ST_POLL_WAIT       = 4'd5,
        ST_POLL_WAIT_TIMER = 4'd6,
        ST_ERROR           = 4'd7
    } seq_state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } init_entry_t;

    // Cycles without a response before a transaction counts as NACKed
    localparam logic [15:0] WATCHDOG_MAX = 16'hFFFF;

endpackage

// File: rtl/i2c_init_rom.sv
// Device configuration table replayed once after start-up.
// Entries past the populated range read back as zero.
module i2c_init_rom
    import i2c_seq_pkg::*;
(
    input  logic [3:0]  idx,
    output init_entry_t entry
);

    // Combinational table lookup
    always_comb begin
        entry = '{reg_addr: 8'h00, data: 8'h00};
        case (idx)
            4'd0:    entry = '{reg_addr: 8'h1E, data: 8'h00}; // soft reset
            4'd1:    entry = '{reg_addr: 8'h0C, data: 8'h10}; // power-down control
            4'd2:    entry = '{reg_addr: 8'h0E, data: 8'h42}; // audio interface format
            4'd3:    entry = '{reg_addr: 8'h10, data: 8'h00}; // sampling control
            4'd4:    entry = '{reg_addr: 8'h08, data: 8'h12}; // analog path
            4'd5:    entry = '{reg_addr: 8'h0A, data: 8'h00}; // digital path
            4'd6:    entry = '{reg_addr: 8'h12, data: 8'h01}; // activate interface
            4'd7:    entry = '{reg_addr: 8'h00, data: 8'h17}; // line-in level
            default: entry = '{reg_addr: 8'h00, data: 8'h00};
        endcase
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// I2C command sequencer: replays the init table to the I2C master after a
// start-up delay, then polls one device register periodically, retrying
// NACKed transactions up to MAX_RETRY times before locking in ERROR.
// Optional build macro I2C_SEQ_TIMEOUT_EN adds a response watchdog that
// turns a silent master into a NACK.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR      = 7'h1A,
    parameter int         INIT_LEN      = 4,
    parameter logic [7:0] POLL_REG      = 8'h00,
    parameter int         POLL_PERIOD   = 1000,
    parameter int         STARTUP_DELAY = 100,
    parameter int         MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_write,
    output logic [6:0] cmd_dev_addr,
    output logic [7:0] cmd_reg_addr,
    output logic [7:0] cmd_wdata,
    input  logic       rsp_valid,
    input  logic       rsp_ack,
    input  logic [7:0] rsp_rdata,
    output logic [7:0] read_byte,
    output logic       read_valid,
    output logic       init_done,
    output logic       error,
    output logic [3:0] state_info
);

    localparam int CNT_MAX = (STARTUP_DELAY > POLL_PERIOD) ? STARTUP_DELAY : POLL_PERIOD;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_DELAY - 1);
    localparam logic [CW-1:0] POLL_LAST    = CW'(POLL_PERIOD - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);
    localparam logic [3:0]    INIT_LAST    = 4'(INIT_LEN - 1);

    seq_state_t    state, next_state;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [RW-1:0] retry;
    init_entry_t   init_entry;
    logic          in_wait;
    logic          timeout;
    logic          rsp_ok;
    logic          rsp_bad;
    logic          can_retry;

    i2c_init_rom u_rom (
        .idx   (idx),
        .entry (init_entry)
    );

    assign in_wait   = (state == ST_INIT_WAIT) || (state == ST_POLL_WAIT);
    // A real response always takes precedence over a watchdog expiry
    assign rsp_ok    = in_wait && rsp_valid && rsp_ack;
    assign rsp_bad   = in_wait && (rsp_valid ? !rsp_ack : timeout);
    assign can_retry = (retry < RETRY_LIMIT);

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Watchdog restarts on every state entry and only advances while waiting
    always_ff @(posedge clk) begin
        if (reset || (next_state != state) || !in_wait) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    assign timeout = in_wait && (wd_cnt == WATCHDOG_MAX - 16'd1);
`else
    assign timeout = 1'b0;
`endif

    assign cmd_dev_addr = DEV_ADDR;
    assign error        = (state == ST_ERROR);
    assign state_info   = state;

    // Next-state decode and command outputs, all derived from the current state
    always_comb begin
        next_state   = state;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_reg_addr = 8'h00;
        cmd_wdata    = 8'h00;
        case (state)
            ST_IDLE: begin
                if (enable) next_state = ST_STARTUP;
            end
            ST_STARTUP: begin
                if (cnt == STARTUP_LAST) begin
                    next_state = init_done ? ST_POLL_ISSUE : ST_INIT_ISSUE;
                end
            end
            ST_INIT_ISSUE: begin
                cmd_valid    = 1'b1;
                cmd_write    = 1'b1;
                cmd_reg_addr = init_entry.reg_addr;
                cmd_wdata    = init_entry.data;
                if (cmd_ready) next_state = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (rsp_ok) begin
                    if (!enable)               next_state = ST_IDLE;
                    else if (idx == INIT_LAST) next_state = ST_POLL_WAIT_TIMER;
                    else                       next_state = ST_INIT_ISSUE;
                end else if (rsp_bad) begin
                    next_state = can_retry ? ST_INIT_ISSUE : ST_ERROR;
                end
            end
            ST_POLL_ISSUE: begin
                cmd_valid    = 1'b1;
                cmd_reg_addr = POLL_REG;
                if (cmd_ready) next_state = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (rsp_ok) begin
                    next_state = enable ? ST_POLL_WAIT_TIMER : ST_IDLE;
                end else if (rsp_bad) begin
                    next_state = can_retry ? ST_POLL_ISSUE : ST_ERROR;
                end
            end
            ST_POLL_WAIT_TIMER: begin
                if (!enable)               next_state = ST_IDLE;
                else if (cnt == POLL_LAST) next_state = ST_POLL_ISSUE;
            end
            ST_ERROR: begin
                next_state = ST_ERROR;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register, delay counter, table index and retry count
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            retry <= '0;
        end else begin
            state <= next_state;
            // Counter restarts on every state change, so it never wraps
            if (next_state != state) begin
                cnt <= '0;
            end else if ((state == ST_STARTUP) || (state == ST_POLL_WAIT_TIMER)) begin
                cnt <= cnt + CW'(1);
            end
            if (rsp_ok) begin
                retry <= '0;
            end else if (rsp_bad && can_retry) begin
                retry <= retry + RW'(1);
            end
            if (rsp_ok && (state == ST_INIT_WAIT)) begin
                idx <= idx + 4'd1;
            end
        end
    end

    // Sticky init flag and the latest poll result
    always_ff @(posedge clk) begin
        if (reset) begin
            init_done  <= 1'b0;
            read_byte  <= 8'h00;
            read_valid <= 1'b0;
        end else begin
            read_valid <= 1'b0;
            if (rsp_ok && (state == ST_INIT_WAIT) && (idx == INIT_LAST)) begin
                init_done <= 1'b1;
            end
            if (rsp_ok && (state == ST_POLL_WAIT)) begin
                read_byte  <= rsp_rdata;
                read_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed-plus-random bench for i2c_cmd_sequencer: plays the I2C master,
// predicts command order, timing and read results from the sequencer rules.
module tb_i2c_cmd_sequencer;

    localparam logic [6:0] DEV    = 7'h1A;
    localparam int         SD     = 100;
    localparam int         PP     = 50;
    localparam int         NRETRY = 3;
    localparam int         NINIT  = 4;
    localparam logic [7:0] PREG   = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ack;
    logic [7:0] rsp_rdata;
    logic [7:0] read_byte;
    logic       read_valid;
    logic       init_done;
    logic       error;
    logic [3:0] state_info;

    i2c_cmd_sequencer #(
        .DEV_ADDR      (DEV),
        .INIT_LEN      (NINIT),
        .POLL_REG      (PREG),
        .POLL_PERIOD   (PP),
        .STARTUP_DELAY (SD),
        .MAX_RETRY     (NRETRY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_dev_addr (cmd_dev_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ack      (rsp_ack),
        .rsp_rdata    (rsp_rdata),
        .read_byte    (read_byte),
        .read_valid   (read_valid),
        .init_done    (init_done),
        .error        (error),
        .state_info   (state_info)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int next_issue  = -1;
    int wait_bound  = 2000;
    logic [7:0]  exp_rbyte = 8'h00;
    logic [15:0] init_tab [NINIT] = '{16'h1E00, 16'h0C10, 16'h0E42, 16'h1000};

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "/cmd"}, 32'({cmd_valid, cmd_write, cmd_reg_addr, cmd_wdata}), 32'd0);
        chk({tag, "/dev"}, 32'(cmd_dev_addr), 32'(DEV));
        chk({tag, "/status"}, 32'({read_byte, read_valid, init_done, error, state_info}), 32'd0);
    endtask

    // Wait for a command, hold it off for 'hold' cycles, then accept it
    task automatic take_cmd(input int hold, output logic w, output logic [7:0] ra,
                            output logic [7:0] wd, output int t_issue, output int t_acc);
        int n;
        n = 0;
        cmd_ready = 1'b0;
        while (!cmd_valid && n < wait_bound) begin
            tick();
            n++;
        end
        chk("cmd_seen", 32'(cmd_valid), 32'd1);
        t_issue = cyc;
        w  = cmd_write;
        ra = cmd_reg_addr;
        wd = cmd_wdata;
        chk("dev_addr", 32'(cmd_dev_addr), 32'(DEV));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("backpressure_hold", 32'({cmd_valid, cmd_write, cmd_reg_addr, cmd_wdata}),
                32'({1'b1, w, ra, wd}));
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        t_acc = cyc;
        chk("one_outstanding", 32'(cmd_valid), 32'd0);
    endtask

    // Deliver a response so that it is sampled 'lat' edges after the accept
    task automatic respond(input int lat, input logic ack, input logic [7:0] rd, output int t_rsp);
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("quiet_in_wait", 32'(cmd_valid), 32'd0);
        end
        rsp_valid = 1'b1;
        rsp_ack   = ack;
        rsp_rdata = rd;
        tick();
        rsp_valid = 1'b0;
        rsp_ack   = 1'b0;
        rsp_rdata = 8'h00;
        t_rsp = cyc;
    endtask

    // One full transaction checked against the expected command and timing
    task automatic do_txn(input string tag, input logic is_init, input int e, input int hold,
                          input int lat, input logic ack, input logic [7:0] rd, input logic drop_en);
        logic w;
        logic [7:0] ra, wd;
        int ti, ta, tr;
        logic [16:0] exp_cmd;
        exp_cmd = is_init ? {1'b1, init_tab[e]} : {1'b0, PREG, 8'h00};
        take_cmd(hold, w, ra, wd, ti, ta);
        if (drop_en) enable = 1'b0;
        chk({tag, "/fields"}, 32'({w, ra, wd}), 32'(exp_cmd));
        if (next_issue >= 0) chk({tag, "/issue_cycle"}, ti, next_issue);
        respond(lat, ack, rd, tr);
        if (ack && !is_init) exp_rbyte = rd;
        chk({tag, "/read"}, 32'({read_valid, read_byte}), 32'({ack && !is_init, exp_rbyte}));
        if (ack && !is_init) begin
            tick();
            chk({tag, "/read_pulse_end"}, 32'(read_valid), 32'd0);
        end
        next_issue = (ack && (!is_init || e == NINIT - 1)) ? tr + PP : tr;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed cycle %0d, required completion", cyc);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        logic w;
        logic [7:0] ra, wd;
        int ti, ta, tr, c, seen, nk;

        reset     = 1'b1;
        enable    = 1'b0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_ack   = 1'b0;
        rsp_rdata = 8'h00;

        // Reset state
        tick();
        tick();
        chk_idle_outs("reset_state");

        // Start-up delay and init table with NACK retries and backpressure
        enable = 1'b1;
        tick();
        reset = 1'b0;
        c = cyc;
        next_issue = c + SD + 1;
        for (int e = 0; e < NINIT; e++) begin
            nk = (e == 1) ? 2 : 0;
            for (int a = 0; a <= nk; a++) begin
                do_txn("init", 1'b1, e, (e == 2) ? 20 : $urandom_range(0, 3), 5,
                       a == nk, 8'h00, 1'b0);
            end
            if (e == NINIT - 2) chk("init_done_early", 32'(init_done), 32'd0);
        end
        chk("init_done_set", 32'({init_done, error, state_info}), 32'({1'b1, 1'b0, 4'd6}));

        // Poll phase with fixed then random read data and retries
        do_txn("poll_a5", 1'b0, 0, $urandom_range(0, 3), $urandom_range(1, 8), 1'b1, 8'hA5, 1'b0);
        do_txn("poll_3c", 1'b0, 0, $urandom_range(0, 3), $urandom_range(1, 8), 1'b1, 8'h3C, 1'b0);
        for (int p = 0; p < 4; p++) begin
            nk = $urandom_range(0, 2);
            for (int a = 0; a <= nk; a++) begin
                do_txn("poll_rand", 1'b0, 0, $urandom_range(0, 3), $urandom_range(1, 8),
                       a == nk, 8'($urandom), 1'b0);
            end
        end

        // Enable dropped mid-poll: retry still completes, then IDLE, then poll without re-init
        do_txn("poll_drop_nack", 1'b0, 0, 0, 3, 1'b0, 8'h11, 1'b1);
        do_txn("poll_drop_ack", 1'b0, 0, 0, 3, 1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        chk("idle_after_drop", 32'({cmd_valid, state_info, init_done}), 32'({1'b0, 4'd0, 1'b1}));
        enable = 1'b1;
        c = cyc;
        next_issue = c + SD + 1;
        do_txn("poll_reenable", 1'b0, 0, 1, 4, 1'b1, 8'hC3, 1'b0);

        // Reset clears everything, then reset again with entry 1 outstanding
        reset = 1'b1;
        tick();
        chk_idle_outs("reset_from_poll");
        exp_rbyte = 8'h00;
        reset = 1'b0;
        c = cyc;
        next_issue = c + SD + 1;
        do_txn("reinit_e0", 1'b1, 0, 0, $urandom_range(1, 8), 1'b1, 8'h00, 1'b0);
        take_cmd(0, w, ra, wd, ti, ta);
        chk("reinit_e1_fields", 32'({w, ra, wd}), 32'({1'b1, init_tab[1]}));
        reset = 1'b1;
        tick();
        chk_idle_outs("reset_mid_txn");
        enable = 1'b0;
        reset  = 1'b0;
        tick();
        tick();
        rsp_valid = 1'b1;
        rsp_ack   = 1'b1;
        rsp_rdata = 8'h77;
        tick();
        rsp_valid = 1'b0;
        rsp_ack   = 1'b0;
        rsp_rdata = 8'h00;
        tick();
        chk_idle_outs("late_rsp_ignored");

        // Init restarts from entry 0; four NACKs exhaust the retries
        enable = 1'b1;
        c = cyc;
        next_issue = c + SD + 1;
        for (int a = 0; a <= NRETRY; a++) begin
            do_txn("nack_to_error", 1'b1, 0, $urandom_range(0, 2), $urandom_range(1, 6),
                   1'b0, 8'h00, 1'b0);
        end
        chk("error_entered", 32'({error, state_info, init_done, cmd_valid}),
            32'({1'b1, 4'd7, 1'b0, 1'b0}));
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 20) begin
                rsp_valid = 1'b1;
                rsp_ack   = 1'b1;
            end else begin
                rsp_valid = 1'b0;
                rsp_ack   = 1'b0;
            end
            tick();
            if (cmd_valid) seen++;
        end
        chk("no_cmd_in_error", seen, 0);
        chk("error_sticky", 32'({error, state_info}), 32'({1'b1, 4'd7}));

`ifdef I2C_SEQ_TIMEOUT_EN
        // Silent master: poll reissued after the watchdog expires
        reset = 1'b1;
        tick();
        reset = 1'b0;
        c = cyc;
        next_issue = c + SD + 1;
        for (int e = 0; e < NINIT; e++) begin
            do_txn("wd_init", 1'b1, e, 0, 2, 1'b1, 8'h00, 1'b0);
        end
        take_cmd(0, w, ra, wd, ti, ta);
        chk("wd_poll_time", ti, next_issue);
        wait_bound = 70000;
        take_cmd(0, w, ra, wd, ti, tr);
        wait_bound = 2000;
        chk("wd_reissue_fields", 32'({w, ra, wd}), 32'({1'b0, PREG, 8'h00}));
        chk("wd_reissue_cycle", ti - ta, 65535);
        respond(2, 1'b1, 8'h96, tr);
        chk("wd_read", 32'({read_valid, read_byte}), 32'({1'b1, 8'h96}));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
